multicycle_control: RTL and testbench



---
 rtl/rv_ctrl_pkg.sv | 91 +++++++++
 rtl/multicycle_control.sv | 257 +++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg
// Shared definitions for the RV32I multi-cycle control path. The main FSM
// (multicycle_control) uses them, and so does ula_control, which decodes
// ula_op together with funct3/funct7.
//
// Contents:
//   - 4-bit state encodings and the state_t enum built from them
//   - RV32I major opcodes recognised by the control FSM
//   - ula_op codes
//   - datapath mux select codes: alu_src_a, alu_src_b, pc_source, mem_to_reg
//   - small helpers for branch qualification

package rv_ctrl_pkg;

  // State encodings. The numeric values are fixed so that debug and trace
  // tooling can decode the state register directly.
  localparam logic [3:0] S_RESET     = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_EXEC_R    = 4'd3;
  localparam logic [3:0] S_EXEC_I    = 4'd4;
  localparam logic [3:0] S_MEM_ADDR  = 4'd5;
  localparam logic [3:0] S_MEM_READ  = 4'd6;
  localparam logic [3:0] S_MEM_WB    = 4'd7;
  localparam logic [3:0] S_MEM_WRITE = 4'd8;
  localparam logic [3:0] S_ALU_WB    = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JAL       = 4'd11;
  localparam logic [3:0] S_TRAP      = 4'd12;

  typedef enum logic [3:0] {
    ST_RESET     = S_RESET,
    ST_FETCH     = S_FETCH,
    ST_DECODE    = S_DECODE,
    ST_EXEC_R    = S_EXEC_R,
    ST_EXEC_I    = S_EXEC_I,
    ST_MEM_ADDR  = S_MEM_ADDR,
    ST_MEM_READ  = S_MEM_READ,
    ST_MEM_WB    = S_MEM_WB,
    ST_MEM_WRITE = S_MEM_WRITE,
    ST_ALU_WB    = S_ALU_WB,
    ST_BRANCH    = S_BRANCH,
    ST_JAL       = S_JAL,
    ST_TRAP      = S_TRAP
  } state_t;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ula_op codes, resolved further by ula_control
  localparam logic [1:0] ULA_ADD    = 2'b00;
  localparam logic [1:0] ULA_SUB    = 2'b01;
  localparam logic [1:0] ULA_R_FUNC = 2'b10;
  localparam logic [1:0] ULA_I_FUNC = 2'b11;

  // ULA operand A select
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

  // ULA operand B select
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  // PC source select
  localparam logic [1:0] PC_SRC_ULA    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

  // Register file write-back source
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  // Only beq (000) and bne (001) are supported. Every other branch funct3
  // is decoded as illegal.
  function automatic logic is_supported_branch(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001);
  endfunction

  // beq is taken on zero. bne is taken on not-zero. funct3[0] flips the sense.
  function automatic logic branch_taken(input logic zero_flag, input logic f3_lsb);
    return zero_flag ^ f3_lsb;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control
// Main control FSM for the multi-cycle RV32I core. It steps the shared
// datapath (one ULA, one memory port, register file, PC) through the
// fetch / decode / execute / memory / write-back phases.
//
// All outputs are decoded from the state register. The outputs that depend
// on inputs are ir_write/pc_write in FETCH (mem_ready), retire in MEM_WRITE
// (mem_ready) and pc_write_cond in BRANCH (zero). No output is registered,
// so a synchronous reset clears every output in the cycle after the reset
// edge. This includes mem_req: the memory must abandon any in-flight access.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   opcode[6:0]    IR[6:0]
//   funct3[2:0]    IR[14:12]
//   zero           ULA zero flag
//   mem_ready      memory completes the current request this cycle
//   mem_req        memory request, held until mem_ready
//   mem_we         write request (stores)
//   i_or_d         memory address select: 0 = PC, 1 = ALUOut
//   ir_write       load IR and old_pc
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if branch taken
//   pc_source[1:0] 00 = ULA result, 01 = ALUOut
//   alu_src_a[1:0] 00 = PC, 01 = rs1, 10 = old_pc
//   alu_src_b[1:0] 00 = rs2, 01 = 4, 10 = immediate
//   ula_op[1:0]    00 add, 01 sub, 10 R-type funct, 11 I-type funct
//   reg_write      register file write
//   mem_to_reg[1:0] 00 = ALUOut, 01 = MDR, 10 = PC (already PC+4)
//   retire         one-cycle pulse per completed instruction
//   illegal        sticky trap flag (held in TRAP until reset)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RESET     | post-reset idle cycle, all outputs 0
// FETCH     | read instruction at PC, PC <= PC+4 when mem_ready
// DECODE    | ALUOut <= old_pc + imm (branch/jump target), dispatch
// EXEC_R    | ALUOut <= rs1 op rs2
// EXEC_I    | ALUOut <= rs1 op imm
// MEM_ADDR  | ALUOut <= rs1 + imm (effective address)
// MEM_READ  | data read at ALUOut, wait for mem_ready
// MEM_WB    | rd <= MDR
// MEM_WRITE | data write at ALUOut, retire on mem_ready
// ALU_WB    | rd <= ALUOut
// BRANCH    | compare rs1/rs2, PC <= ALUOut if taken
// JAL       | rd <= PC (already +4), PC <= ALUOut
// TRAP      | illegal instruction, parked until reset

module multicycle_control
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ula_op,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       retire,
  output logic       illegal
);

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET: state_next = ST_FETCH;

      ST_FETCH: begin
        if (mem_ready) begin
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (opcode == OP_R_TYPE) begin
          state_next = ST_EXEC_R;
        end else if (opcode == OP_I_TYPE) begin
          state_next = ST_EXEC_I;
        end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          state_next = ST_MEM_ADDR;
        end else if ((opcode == OP_BRANCH) && is_supported_branch(funct3)) begin
          state_next = ST_BRANCH;
        end else if (opcode == OP_JAL) begin
          state_next = ST_JAL;
        end else begin
          state_next = ST_TRAP;
        end
      end

      ST_EXEC_R: state_next = ST_ALU_WB;
      ST_EXEC_I: state_next = ST_ALU_WB;
      ST_ALU_WB: state_next = ST_FETCH;

      // The IR was checked in DECODE, so anything that is not a load here
      // must be a store.
      ST_MEM_ADDR: begin
        if (opcode == OP_LOAD) begin
          state_next = ST_MEM_READ;
        end else begin
          state_next = ST_MEM_WRITE;
        end
      end

      ST_MEM_READ: begin
        if (mem_ready) begin
          state_next = ST_MEM_WB;
        end
      end

      ST_MEM_WB: state_next = ST_FETCH;

      ST_MEM_WRITE: begin
        if (mem_ready) begin
          state_next = ST_FETCH;
        end
      end

      ST_BRANCH: state_next = ST_FETCH;
      ST_JAL:    state_next = ST_FETCH;
      ST_TRAP:   state_next = ST_TRAP;

      default:   state_next = ST_RESET;
    endcase
  end

  // Output decode. Every output defaults to 0, and each state sets only the
  // lines it uses.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PC_SRC_ULA;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    ula_op        = ULA_ADD;
    reg_write     = 1'b0;
    mem_to_reg    = WB_ALUOUT;
    retire        = 1'b0;
    illegal       = 1'b0;

    case (state)
      ST_FETCH: begin
        // The ULA computes PC+4 every FETCH cycle. The PC and IR capture
        // only on the transfer cycle, so a stalled fetch keeps the old PC.
        mem_req   = 1'b1;
        i_or_d    = 1'b0;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        ula_op    = ULA_ADD;
        pc_source = PC_SRC_ULA;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end

      ST_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        ula_op    = ULA_ADD;
      end

      ST_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        ula_op    = ULA_R_FUNC;
      end

      ST_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        ula_op    = ULA_I_FUNC;
      end

      ST_ALU_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_ALUOUT;
        retire     = 1'b1;
      end

      ST_MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        ula_op    = ULA_ADD;
      end

      ST_MEM_READ: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end

      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_MDR;
        retire     = 1'b1;
      end

      ST_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        retire  = mem_ready;
      end

      ST_BRANCH: begin
        alu_src_a     = SRC_A_RS1;
        alu_src_b     = SRC_B_RS2;
        ula_op        = ULA_SUB;
        pc_source     = PC_SRC_ALUOUT;
        pc_write_cond = branch_taken(zero, funct3[0]);
        retire        = 1'b1;
      end

      ST_JAL: begin
        // The PC already holds old_pc+4 from FETCH, which is the link value.
        reg_write  = 1'b1;
        mem_to_reg = WB_PC;
        pc_write   = 1'b1;
        pc_source  = PC_SRC_ALUOUT;
        retire     = 1'b1;
      end

      ST_TRAP: begin
        illegal = 1'b1;
      end

      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_a, alu_src_b, ula_op, mem_to_reg;
  logic       reg_write, retire, illegal;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ula_op(ula_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ula_op;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       retire;
    logic       illegal;
  } ctl_t;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_ILL = 6;

  ctl_t got;
  ctl_t exp_ctl;
  logic exp_valid = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc_n = 0;
  int   retire_cyc = -1;

  assign got = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
                pc_source, alu_src_a, alu_src_b, ula_op, reg_write, mem_to_reg,
                retire, illegal};

  // Single per-cycle compare against the expectation the model set up for
  // this cycle. Also records the cycle index of every retire pulse.
  always @(negedge clk) begin
    if (exp_valid) begin
      n_checks = n_checks + 1;
      if (got !== exp_ctl) begin
        n_fail = n_fail + 1;
        $display("FAIL ctl cycle %0d op=%b f3=%b: got %b expected %b",
                 cyc_n, opcode, funct3, got, exp_ctl);
      end
    end
    if (retire === 1'b1) retire_cyc = cyc_n;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction class from the architectural opcode/funct3 rules
  function automatic int kind_of(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return (f3 <= 3'd1) ? K_BR : K_ILL;
      7'b1101111: return K_JAL;
      default:    return K_ILL;
    endcase
  endfunction

  // Zero-wait latency per class. Wait states are added on top of it.
  function automatic int base_lat(input int k);
    case (k)
      K_R, K_I, K_ST: return 4;
      K_LD:           return 5;
      default:        return 3;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_checks = n_checks + 1;
    if (act !== expv) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Drive one cycle of inputs and post its expected outputs
  task automatic cyc(input ctl_t e, input logic mr, input logic z);
    mem_ready = mr;
    zero      = z;
    exp_ctl   = e;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
    cyc_n = cyc_n + 1;
  endtask

  // Drive reset low for n_low cycles. The first cycle still shows the
  // pre-reset state's outputs. After release there is one RESET cycle.
  task automatic do_reset(input ctl_t first, input logic first_mr, input int n_low);
    ctl_t z0;
    z0 = '0;
    rst_n = 1'b0;
    cyc(first, first_mr, rb());
    repeat (n_low - 1) cyc(z0, 1'b1, rb());
    rst_n = 1'b1;
    cyc(z0, rb(), rb());
  endtask

  // Run one instruction from FETCH. w1 = fetch wait cycles, w2 = data wait
  // cycles, trap_n = cycles to observe if illegal. With abort set, a load
  // or store stops after its w2 wait cycles without completing.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic zv,
                           input int w1, input int w2, input int trap_n,
                           input bit abort, output int lat);
    ctl_t e;
    int   k;
    int   start;
    k      = kind_of(op, f3);
    opcode = op;
    funct3 = f3;
    start  = cyc_n;
    repeat (w1) begin
      e = '0; e.mem_req = 1'b1; e.alu_src_b = 2'b01;
      cyc(e, 1'b0, rb());
    end
    e = '0; e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cyc(e, 1'b1, rb());
    e = '0; e.alu_src_a = 2'b10; e.alu_src_b = 2'b10;
    cyc(e, rb(), rb());
    case (k)
      K_R, K_I: begin
        e = '0; e.alu_src_a = 2'b01;
        e.alu_src_b = (k == K_R) ? 2'b00 : 2'b10;
        e.ula_op    = (k == K_R) ? 2'b10 : 2'b11;
        cyc(e, rb(), rb());
        e = '0; e.reg_write = 1'b1; e.retire = 1'b1;
        cyc(e, rb(), rb());
      end
      K_LD, K_ST: begin
        e = '0; e.alu_src_a = 2'b01; e.alu_src_b = 2'b10;
        cyc(e, rb(), rb());
        e = '0; e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_we = (k == K_ST);
        repeat (w2) cyc(e, 1'b0, rb());
        if (!abort) begin
          if (k == K_ST) begin
            e.retire = 1'b1;
            cyc(e, 1'b1, rb());
          end else begin
            cyc(e, 1'b1, rb());
            e = '0; e.reg_write = 1'b1; e.mem_to_reg = 2'b01; e.retire = 1'b1;
            cyc(e, rb(), rb());
          end
        end
      end
      K_BR: begin
        e = '0; e.alu_src_a = 2'b01; e.ula_op = 2'b01; e.pc_source = 2'b01;
        e.retire = 1'b1; e.pc_write_cond = zv ^ f3[0];
        cyc(e, rb(), zv);
      end
      K_JAL: begin
        e = '0; e.reg_write = 1'b1; e.mem_to_reg = 2'b10; e.pc_write = 1'b1;
        e.pc_source = 2'b01; e.retire = 1'b1;
        cyc(e, rb(), rb());
      end
      default: begin
        repeat (trap_n) begin
          e = '0; e.illegal = 1'b1;
          cyc(e, rb(), rb());
        end
      end
    endcase
    lat = retire_cyc - start + 1;
  endtask

  initial begin
    ctl_t e;
    ctl_t z0;
    int   lat;
    int   saved;
    int   k;
    logic [6:0] op;
    logic [2:0] f3;
    int   w1, w2;
    z0 = '0;

    rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Reset held 3 cycles with mem_ready high: everything must stay 0
    repeat (3) cyc(z0, 1'b1, rb());
    rst_n = 1'b1;
    cyc(z0, 1'b1, rb());

    // Directed cases with hand-computed latencies
    run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, 0, 1'b0, lat); check("lat_rtype", lat, 4);
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 2, 0, 1'b0, lat); check("lat_load_w2", lat, 7);
    run_instr(7'b0100011, 3'b010, 1'b0, 0, 0, 0, 1'b0, lat); check("lat_store", lat, 4);
    run_instr(7'b1100011, 3'b000, 1'b1, 0, 0, 0, 1'b0, lat); check("lat_beq_taken", lat, 3);
    run_instr(7'b1100011, 3'b001, 1'b1, 0, 0, 0, 1'b0, lat); check("lat_bne_not", lat, 3);
    run_instr(7'b1101111, 3'b000, 1'b0, 0, 0, 0, 1'b0, lat); check("lat_jal", lat, 3);
    run_instr(7'b0010011, 3'b000, 1'b0, 1, 0, 0, 1'b0, lat); check("lat_itype_w1", lat, 5);

    // Illegal opcode: TRAP for 10 cycles, then reset out of it
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 10, 1'b0, lat);
    e = '0; e.illegal = 1'b1;
    do_reset(e, 1'b1, 2);

    // Reset during a stalled store: request drops, no retire
    run_instr(7'b0100011, 3'b000, 1'b0, 0, 2, 0, 1'b1, lat);
    saved = retire_cyc;
    e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.i_or_d = 1'b1;
    do_reset(e, 1'b0, 2);
    check("no_retire_after_abort", retire_cyc, saved);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 19);
      f3 = 3'($urandom_range(0, 7));
      if (k < 3)       op = 7'b0110011;
      else if (k < 6)  op = 7'b0010011;
      else if (k < 9)  op = 7'b0000011;
      else if (k < 12) op = 7'b0100011;
      else if (k < 16) begin
        op = 7'b1100011;
        if (k != 15) f3 = {2'b00, f3[0]};
      end
      else if (k < 19) op = 7'b1101111;
      else             op = 7'($urandom_range(0, 127));
      w1 = $urandom_range(0, 3);
      w2 = $urandom_range(0, 3);
      run_instr(op, f3, rb(), w1, w2, $urandom_range(1, 4), 1'b0, lat);
      k = kind_of(op, f3);
      if (k == K_ILL) begin
        e = '0; e.illegal = 1'b1;
        do_reset(e, 1'b1, $urandom_range(1, 3));
      end else begin
        check("lat_random", lat,
              base_lat(k) + w1 + (((k == K_LD) || (k == K_ST)) ? w2 : 0));
      end
    end

    exp_valid = 1'b0;
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
